// File: rtl/mem_ctrl.sv
// mem_ctrl: one-outstanding memory controller. Decodes each request to on-chip
// SRAM (programmable wait states), an external IO bus (with timeout) or an error.
package mem_ctrl_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 0,
    parameter int IO_TIMEOUT  = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  mem_in_type                   mem_in,
    output mem_out_type                  mem_out,
    output logic                         ram_en,
    output logic [3:0]                   ram_wstrb,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    output logic                         io_valid,
    output logic [31:0]                  io_addr,
    output logic [31:0]                  io_wdata,
    output logic [3:0]                   io_wstrb,
    input  logic                         io_ready,
    input  logic [31:0]                  io_rdata,
    output logic                         bus_error
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [15:0] TMO_LAST  = 16'(IO_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_RAM_ACC, S_RAM_WAIT, S_IO_ACC, S_RESP} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_wcnt;
    logic [15:0]   r_tcnt;
    logic          r_rd;
    logic          r_ready, r_berr, r_ram_en, r_io_valid;
    logic [31:0]   r_rdata, r_ram_wdata, r_io_addr, r_io_wdata;
    logic [3:0]    r_ram_wstrb, r_io_wstrb;
    logic [AW-1:0] r_ram_addr;

    logic          w_accept, w_is_ram, w_is_io, w_ram_done, w_io_ack, w_io_tmo;
    logic          w_ready, w_berr, w_ram_en, w_io_valid;
    logic [31:0]   w_rdata, w_ram_wdata, w_io_addr, w_io_wdata;
    logic [3:0]    w_ram_wstrb, w_io_wstrb;
    logic [AW-1:0] w_ram_addr;
    logic          w_unused_ok;

    // RESP also accepts, so back-to-back requests need no idle cycle.
    assign w_accept    = mem_in.mem_valid && (r_state == S_IDLE || r_state == S_RESP);
    assign w_is_ram    = {1'b0, mem_in.mem_addr} < RAM_BYTES;
    assign w_is_io     = mem_in.mem_addr[31:28] == 4'h1;
    assign w_ram_done  = (r_state == S_RAM_WAIT) && (r_wcnt == WAIT_LAST);
    assign w_io_ack    = (r_state == S_IO_ACC) && io_ready;
    assign w_io_tmo    = (r_state == S_IO_ACC) && !io_ready && (r_tcnt == TMO_LAST);
    assign w_unused_ok = mem_in.mem_instr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) w_next = w_is_ram ? S_RAM_ACC : (w_is_io ? S_IO_ACC : S_RESP);
                else          w_next = S_IDLE;
            end
            S_RAM_ACC:  w_next = S_RAM_WAIT;
            S_RAM_WAIT: if (w_ram_done) w_next = S_RESP;
            S_IO_ACC:   if (w_io_ack || w_io_tmo) w_next = S_RESP;
            default:    w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything defaults to zero so
    // the bus fields are clean whenever their strobe is low.
    always_comb begin
        w_ready     = 1'b0;
        w_berr      = 1'b0;
        w_rdata     = '0;
        w_ram_en    = 1'b0;
        w_ram_wstrb = '0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        w_io_valid  = 1'b0;
        w_io_addr   = '0;
        w_io_wdata  = '0;
        w_io_wstrb  = '0;
        if (w_accept) begin
            if (w_is_ram) begin
                w_ram_en    = 1'b1;
                w_ram_wstrb = mem_in.mem_wstrb;
                w_ram_addr  = mem_in.mem_addr[AW+1:2];
                w_ram_wdata = mem_in.mem_wdata;
            end else if (w_is_io) begin
                w_io_valid = 1'b1;
                w_io_addr  = mem_in.mem_addr;
                w_io_wdata = mem_in.mem_wdata;
                w_io_wstrb = mem_in.mem_wstrb;
            end else begin
                w_ready = 1'b1;
                w_berr  = 1'b1;
            end
        end else if (w_ram_done) begin
            w_ready = 1'b1;
            w_rdata = r_rd ? ram_rdata : '0;
        end else if (w_io_ack) begin
            w_ready = 1'b1;
            w_rdata = r_rd ? io_rdata : '0;
        end else if (w_io_tmo) begin
            w_ready = 1'b1;
            w_berr  = 1'b1;
        end else if (r_state == S_IO_ACC) begin
            w_io_valid = 1'b1;
            w_io_addr  = r_io_addr;
            w_io_wdata = r_io_wdata;
            w_io_wstrb = r_io_wstrb;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wcnt      <= '0;
            r_tcnt      <= '0;
            r_rd        <= 1'b0;
            r_ready     <= 1'b0;
            r_berr      <= 1'b0;
            r_rdata     <= '0;
            r_ram_en    <= 1'b0;
            r_ram_wstrb <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_io_valid  <= 1'b0;
            r_io_addr   <= '0;
            r_io_wdata  <= '0;
            r_io_wstrb  <= '0;
        end else begin
            r_wcnt      <= (r_state == S_RAM_WAIT) ? r_wcnt + 4'd1 : 4'd0;
            r_tcnt      <= (r_state == S_IO_ACC && !io_ready) ? r_tcnt + 16'd1 : 16'd0;
            if (w_accept) r_rd <= (mem_in.mem_wstrb == 4'b0);
            r_ready     <= w_ready;
            r_berr      <= w_berr;
            r_rdata     <= w_rdata;
            r_ram_en    <= w_ram_en;
            r_ram_wstrb <= w_ram_wstrb;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_io_valid  <= w_io_valid;
            r_io_addr   <= w_io_addr;
            r_io_wdata  <= w_io_wdata;
            r_io_wstrb  <= w_io_wstrb;
        end
    end

    assign mem_out.mem_ready = r_ready;
    assign mem_out.mem_rdata = r_rdata;
    assign bus_error         = r_berr;
    assign ram_en            = r_ram_en;
    assign ram_wstrb         = r_ram_wstrb;
    assign ram_addr          = r_ram_addr;
    assign ram_wdata         = r_ram_wdata;
    assign io_valid          = r_io_valid;
    assign io_addr           = r_io_addr;
    assign io_wdata          = r_io_wdata;
    assign io_wstrb          = r_io_wstrb;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: random requests, a reference memory/IO model predicts every
// response, SRAM strobe and IO request window; monitors pop and compare.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int RW      = 256;
    localparam int AW      = 8;
    localparam int WC      = 2;
    localparam int TMO     = 8;
    localparam int RAM_LAT = 3 + WC;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sram_clr = 1'b1;
    mem_in_type    mi;
    mem_out_type   mo;
    logic          ram_en;
    logic [3:0]    ram_wstrb;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          io_valid;
    logic [31:0]   io_addr, io_wdata;
    logic [3:0]    io_wstrb;
    logic          io_ready;
    logic [31:0]   io_rdata;
    logic          bus_error;

    always #5 clock = ~clock;

    mem_ctrl #(.RAM_WORDS(RW), .WAIT_CYCLES(WC), .IO_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .mem_in(mi), .mem_out(mo),
        .ram_en(ram_en), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_wstrb(io_wstrb), .io_ready(io_ready), .io_rdata(io_rdata),
        .bus_error(bus_error)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous SRAM device: data valid the cycle after ram_en.
    logic [31:0] sram [RW];
    always @(posedge clock) begin
        if (sram_clr) begin
            for (int i = 0; i < RW; i++) sram[i] <= '0;
        end else if (ram_en) begin
            ram_rdata <= sram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct { int cyc; logic [31:0] rdata; logic berr; } resp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } ram_t;
    typedef struct { int s; int e; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } io_t;
    resp_t resp_q[$];
    ram_t  ram_q[$];
    io_t   io_q[$];
    logic [31:0] ref_mem [RW];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Response / SRAM / IO monitor
    initial begin
        resp_t r;
        ram_t  ra;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                if (mo.mem_ready) begin
                    chk("resp_pending", 32'(resp_q.size() != 0), 32'd1);
                    if (resp_q.size() != 0) begin
                        r = resp_q.pop_front();
                        chk("ready_cycle", 32'(cyc), 32'(r.cyc));
                        chk("rdata", mo.mem_rdata, r.rdata);
                        chk("bus_error", 32'(bus_error), 32'(r.berr));
                    end
                end else begin
                    chk("bus_error_idle", 32'(bus_error), 32'd0);
                end
                if (ram_en) begin
                    chk("ram_pending", 32'(ram_q.size() != 0), 32'd1);
                    if (ram_q.size() != 0) begin
                        ra = ram_q.pop_front();
                        chk("ram_cycle", 32'(cyc), 32'(ra.cyc));
                        chk("ram_addr", 32'(ram_addr), 32'(ra.addr));
                        chk("ram_wstrb", 32'(ram_wstrb), 32'(ra.wstrb));
                        chk("ram_wdata", ram_wdata, ra.wdata);
                    end
                end else begin
                    chk("ram_idle_bus", ram_wdata | 32'(ram_wstrb), 32'd0);
                end
                if (io_q.size() != 0 && cyc >= io_q[0].s && cyc <= io_q[0].e) begin
                    chk("io_valid", 32'(io_valid), 32'd1);
                    chk("io_addr", io_addr, io_q[0].addr);
                    chk("io_wdata", io_wdata, io_q[0].wdata);
                    chk("io_wstrb", 32'(io_wstrb), 32'(io_q[0].wstrb));
                    if (cyc == io_q[0].e) void'(io_q.pop_front());
                end else begin
                    chk("io_idle_valid", 32'(io_valid), 32'd0);
                    chk("io_idle_bus", io_addr | io_wdata | 32'(io_wstrb), 32'd0);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(mo.mem_ready), 32'd0);
        chk({tag, "_rdata"}, mo.mem_rdata, 32'd0);
        chk({tag, "_ram"}, 32'(ram_en) | 32'(ram_wstrb) | 32'(ram_addr) | ram_wdata, 32'd0);
        chk({tag, "_io"}, 32'(io_valid) | io_addr | io_wdata | 32'(io_wstrb), 32'd0);
        chk({tag, "_bus_error"}, 32'(bus_error), 32'd0);
    endtask

    // Issue one request in the current cycle (must be IDLE or RESP); returns in
    // its RESP cycle with the request still presented. n: IO ready cycle, 0 = never.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int n, input logic [31:0] iodat);
        int    c;
        bit    is_ram, is_io, rd, done;
        resp_t r;
        ram_t  ra;
        io_t   ia;
        c      = cyc;
        is_ram = ({32'b0, addr} < 64'(RW * 4));
        is_io  = !is_ram && (addr[31:28] == 4'h1);
        rd     = (wstrb == 4'h0);
        io_ready = 1'b0;
        mi.mem_valid = 1'b1;
        mi.mem_instr = 1'($urandom);
        mi.mem_addr  = addr;
        mi.mem_wdata = wdata;
        mi.mem_wstrb = wstrb;
        r.rdata = '0;
        r.berr  = 1'b0;
        if (is_ram) begin
            ra.cyc = c + 1; ra.addr = addr[AW+1:2]; ra.wstrb = wstrb; ra.wdata = wdata;
            ram_q.push_back(ra);
            r.cyc = c + RAM_LAT;
            if (rd) r.rdata = ref_mem[addr[AW+1:2]];
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) ref_mem[addr[AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
        end else if (is_io) begin
            ia.s = c + 1; ia.addr = addr; ia.wdata = wdata; ia.wstrb = wstrb;
            if (n >= 1) begin
                ia.e = c + n;
                r.cyc = c + n + 1;
                if (rd) r.rdata = iodat;
            end else begin
                ia.e = c + TMO + 1;
                r.cyc = c + TMO + 2;
                r.berr = 1'b1;
            end
            io_q.push_back(ia);
        end else begin
            r.cyc = c + 1;
            r.berr = 1'b1;
        end
        resp_q.push_back(r);
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clock); #1;
            // after a timeout, a late io_ready in the RESP cycle must be ignored
            io_ready = is_io && ((n >= 1 && k == n) || (n == 0 && k == TMO + 2));
            io_rdata = (is_io && n >= 1 && k == n) ? iodat : $urandom;
            done = mo.mem_ready;
        end
        chk("txn_complete", 32'(done), 32'd1);
    endtask

    task automatic idle(input int cycles);
        mi.mem_valid = 1'b0;
        mi.mem_addr  = $urandom;
        mi.mem_wdata = $urandom;
        mi.mem_wstrb = 4'($urandom);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            io_ready = 1'b0;
            io_rdata = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int          kind, n;
        logic [31:0] a, wd, rnd;
        logic [3:0]  ws, top;
        mi       = '0;
        io_ready = 1'b0;
        io_rdata = '0;
        for (int i = 0; i < RW; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        sram_clr = 1'b0;
        reset    = 1'b1;
        idle(1);

        // Directed cases
        do_txn(32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 32'h0);
        do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'h0);
        do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'h0);
        idle(2);
        do_txn(32'h1000_0004, 32'h0, 4'h0, 4, 32'h12345678);
        idle(1);
        do_txn(32'h1000_0008, 32'hCAFEF00D, 4'h3, 0, 32'h0);
        idle(2);
        do_txn(32'h8000_0000, 32'h0, 4'h0, 0, 32'h0);
        idle(1);
        do_txn(32'h8000_0000, 32'h1234_5678, 4'hF, 0, 32'h0);
        do_txn(32'(RW * 4 - 4), 32'hA5A5_5A5A, 4'hF, 0, 32'h0);
        do_txn(32'(RW * 4), 32'h0, 4'h0, 0, 32'h0);
        do_txn(32'(RW * 4 - 4), 32'h0, 4'h0, 0, 32'h0);
        do_txn(32'h1FFF_FFFC, 32'h0, 4'h0, TMO + 1, 32'h0BAD_F00D);
        idle(2);

        // Reset in the middle of a RAM read (during the wait states)
        mi.mem_valid = 1'b1; mi.mem_addr = 32'h10; mi.mem_wdata = '0; mi.mem_wstrb = '0;
        begin
            ram_t ra;
            ra.cyc = cyc + 1; ra.addr = 8'd4; ra.wstrb = 4'h0; ra.wdata = 32'h0;
            ram_q.push_back(ra);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        mi.mem_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        idle(6);
        do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'h0);
        idle(1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            wd   = $urandom;
            n    = 0;
            rnd  = $urandom;
            if (kind <= 2) begin
                a = 32'($urandom_range(0, RW * 4 - 1)); ws = 4'($urandom_range(1, 15));
            end else if (kind <= 5) begin
                a = 32'($urandom_range(0, RW * 4 - 1)); ws = 4'h0;
            end else if (kind <= 7) begin
                a = {4'h1, rnd[27:0]}; ws = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
                n = $urandom_range(0, TMO + 1);
            end else if (kind == 8) begin
                top = 4'($urandom_range(2, 15));
                a = ($urandom_range(0, 1) != 0) ? {top, rnd[27:0]}
                                                : 32'(RW * 4) + 32'($urandom_range(0, 32'h0FF0_0000));
                ws = 4'($urandom);
            end else begin
                a = ($urandom_range(0, 1) != 0) ? 32'(RW * 4 - 4) : 32'(RW * 4);
                ws = 4'($urandom);
            end
            do_txn(a, wd, ws, n, $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(4);

        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("ram_q_drained", 32'(ram_q.size()), 32'd0);
        chk("io_q_drained", 32'(io_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
